// File: rtl/mux_scan_pkg.sv
// Shared types, widths and priority-find helpers for the mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned SCAN_W = 16;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

    // Lowest set bit; later (lower) hits overwrite earlier ones.
    function automatic logic [SEL_W-1:0] find_lsb(input logic [SCAN_W-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SCAN_W; i++) begin
            if (v[SCAN_W-1-i]) r = SEL_W'(SCAN_W-1-i);
        end
        return r;
    endfunction

    // Highest set bit; later (higher) hits overwrite earlier ones.
    function automatic logic [SEL_W-1:0] find_msb(input logic [SCAN_W-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SCAN_W; i++) begin
            if (v[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mux16to1.sv
// 16:1 single-bit multiplexer used by the scan sequencer.
module mux16to1
    import mux_scan_pkg::*;
(
    input  logic [SCAN_W-1:0] data,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);

    assign y = data[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks a 16:1 mux select over the masked positions of a captured word,
// presenting each selected bit under a valid/ready handshake.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SCAN_W-1:0] data,
    input  logic [SCAN_W-1:0] mask,
    output logic [SEL_W-1:0]  sel,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SCAN_W-1:0]   data_q, data_d;
    logic [SCAN_W-1:0]   pend_q, pend_d;
    logic [SCAN_W-1:0]   pend_left;
    logic                mux_bit;

    function automatic logic [SEL_W-1:0] pick(input logic [SCAN_W-1:0] v);
        return (LSB_FIRST != 0) ? find_lsb(v) : find_msb(v);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        pend_d    = pend_q;
        pend_left = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d = data;
                    pend_d = mask;
                    if (mask != '0) begin
                        sel_d   = pick(mask);
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SCAN: begin
                // Earlier positions are already cleared, so the next one in
                // scan order is simply the first remaining pending bit.
                if (bit_ready) begin
                    pend_left = pend_q & ~(SCAN_W'(1) << sel_q);
                    pend_d    = pend_left;
                    if (pend_left != '0) begin
                        sel_d = pick(pend_left);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    mux16to1 u_mux (
        .data (data_q),
        .sel  (sel_q),
        .y    (mux_bit)
    );

    assign sel       = sel_q;
    assign bit_valid = (state_q == ST_SCAN);
    assign bit_out   = mux_bit & bit_valid;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one LSB-first and one MSB-first instance checked
// against an ordered-queue model of the enabled positions.
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rst;

    logic        start_l, bit_ready_l, bit_out_l, bit_valid_l, busy_l, done_l;
    logic [15:0] data_l, mask_l;
    logic [3:0]  sel_l;

    logic        start_m, bit_ready_m, bit_out_m, bit_valid_m, busy_m, done_m;
    logic [15:0] data_m, mask_m;
    logic [3:0]  sel_m;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mux_scan_ctrl #(.LSB_FIRST(1)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .start     (start_l),
        .data      (data_l),
        .mask      (mask_l),
        .sel       (sel_l),
        .bit_out   (bit_out_l),
        .bit_valid (bit_valid_l),
        .bit_ready (bit_ready_l),
        .busy      (busy_l),
        .done      (done_l)
    );

    mux_scan_ctrl #(.LSB_FIRST(0)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .start     (start_m),
        .data      (data_m),
        .mask      (mask_m),
        .sel       (sel_m),
        .bit_out   (bit_out_m),
        .bit_valid (bit_valid_m),
        .bit_ready (bit_ready_m),
        .busy      (busy_m),
        .done      (done_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_outs(input bit inst, output logic [3:0] s, output logic b,
                            output logic v, output logic bs, output logic dn);
        if (inst) begin
            s = sel_m; b = bit_out_m; v = bit_valid_m; bs = busy_m; dn = done_m;
        end else begin
            s = sel_l; b = bit_out_l; v = bit_valid_l; bs = busy_l; dn = done_l;
        end
    endtask

    task automatic drive(input bit inst, input logic st, input logic [15:0] d,
                         input logic [15:0] m, input logic rdy);
        if (inst) begin
            start_m = st; data_m = d; mask_m = m; bit_ready_m = rdy;
        end else begin
            start_l = st; data_l = d; mask_l = m; bit_ready_l = rdy;
        end
    endtask

    // inst 0 scans upward, inst 1 downward. hold_sel stalls 3 cycles there.
    task automatic run_scan(input bit inst, input logic [15:0] d, input logic [15:0] m,
                            input int unsigned rdy_pct, input bit noise,
                            input int hold_sel, input string tag);
        logic [3:0] q[$];
        logic [3:0] s;
        logic       b, v, bs, dn, rdy, st;
        int         stall;
        int         cyc;
        int         idx;
        stall = 0;
        cyc   = 0;
        for (int k = 0; k < 16; k++) begin
            idx = inst ? 15 - k : k;
            if (m[4'(idx)]) q.push_back(4'(idx));
        end
        @(negedge clk);
        drive(inst, 1'b1, d, m, 1'b1);
        @(posedge clk);
        #1;
        drive(inst, 1'b0, d, m, 1'b1);
        while (1) begin
            get_outs(inst, s, b, v, bs, dn);
            if (cyc > 100) begin
                chk({tag, " timeout"}, 32'(1), 32'(0));
                break;
            end
            st = noise ? 1'($urandom_range(1)) : 1'b0;
            if (q.size() != 0) begin
                chk({tag, " valid"}, 32'(v), 32'(1));
                chk({tag, " sel"}, 32'(s), 32'(q[0]));
                chk({tag, " bit"}, 32'(b), 32'(d[q[0]]));
                chk({tag, " busy"}, 32'(bs), 32'(1));
                chk({tag, " done_early"}, 32'(dn), 32'(0));
                rdy = ($urandom_range(99) < rdy_pct);
                if (int'(q[0]) == hold_sel && stall < 3) begin
                    rdy = 1'b0;
                    stall++;
                end
                if (rdy) void'(q.pop_front());
                drive(inst, st, noise ? 16'($urandom) : d, noise ? 16'($urandom) : m, rdy);
            end else begin
                chk({tag, " done"}, 32'(dn), 32'(1));
                chk({tag, " busy_done"}, 32'(bs), 32'(1));
                chk({tag, " valid_done"}, 32'(v), 32'(0));
                chk({tag, " bit_done"}, 32'(b), 32'(0));
                drive(inst, st, noise ? 16'($urandom) : d, noise ? 16'($urandom) : m, 1'b1);
                @(posedge clk);
                #1;
                drive(inst, 1'b0, d, m, 1'b1);
                get_outs(inst, s, b, v, bs, dn);
                chk({tag, " busy_idle"}, 32'(bs), 32'(0));
                chk({tag, " done_idle"}, 32'(dn), 32'(0));
                chk({tag, " valid_idle"}, 32'(v), 32'(0));
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        drive(inst, 1'b0, d, m, 1'b1);
    endtask

    initial begin
        logic [15:0] m;
        logic [3:0]  s;
        logic        b, v, bs, dn;
        int          cyc;
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            get_outs(i[0], s, b, v, bs, dn);
            chk("reset sel", 32'(s), 32'(0));
            chk("reset bit_out", 32'(b), 32'(0));
            chk("reset valid", 32'(v), 32'(0));
            chk("reset busy", 32'(bs), 32'(0));
            chk("reset done", 32'(dn), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        run_scan(1'b0, 16'h3f0a, 16'hffff, 100, 1'b0, -1, "full_lsb");
        run_scan(1'b0, 16'h3f0a, 16'h1041, 100, 1'b0, -1, "sparse");
        run_scan(1'b0, 16'h3f0a, 16'h0000, 100, 1'b0, -1, "zero_mask");
        run_scan(1'b0, 16'h3f0a, 16'hffff, 100, 1'b0, 3, "backpressure");
        run_scan(1'b1, 16'h8000, 16'h8001, 100, 1'b0, -1, "msb_ends");
        run_scan(1'b1, 16'h3f0a, 16'hffff, 100, 1'b1, 9, "full_msb");

        for (int i = 0; i < 24; i++) begin
            m = 16'($urandom);
            case (i % 8)
                0: m = '0;
                1: m = '1;
                2: m = 16'(1) << $urandom_range(15);
                default: ;
            endcase
            run_scan(i[0], 16'($urandom), m, 70, 1'b1, -1, "random");
        end

        // Abort a scan with reset once sel reaches 5.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h3f0a, 16'hffff, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h3f0a, 16'hffff, 1'b1);
        cyc = 0;
        while (sel_l != 4'd5 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst reach_sel5", 32'(sel_l), 32'(5));
        #2;
        rst = 1'b1;
        #1;
        get_outs(1'b0, s, b, v, bs, dn);
        chk("rst sel", 32'(s), 32'(0));
        chk("rst bit_out", 32'(b), 32'(0));
        chk("rst valid", 32'(v), 32'(0));
        chk("rst busy", 32'(bs), 32'(0));
        chk("rst done", 32'(dn), 32'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst no_done", 32'(done_l), 32'(0));
            chk("rst no_valid", 32'(bit_valid_l), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        run_scan(1'b0, 16'ha5c3, 16'hf0f0, 100, 1'b0, -1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
